jt900h_ramarb: RTL and testbench



---
 rtl/jt900h_ramarb.sv | 142 ++++++++++++++
 tb/tb_jt900h_ramarb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_ramarb.sv
// jt900h_ramarb: round-robin read arbiter that shares one jt900h_ramctl between the fetch and data ports.
// Optional feature: define JT900H_RAMARB_CACHE_EN to add a one-entry read cache per port.
module jt900h_ramarb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        f_req,
  input  logic [23:0] f_addr,
  output logic [31:0] f_dout,
  output logic        f_rdy,
  input  logic        d_req,
  input  logic [23:0] d_addr,
  output logic [31:0] d_dout,
  output logic        d_rdy,
  output logic [23:0] ctl_addr,
  input  logic [31:0] ctl_dout,
  input  logic        ctl_rdy,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic        settle;
  logic        last_d;
  logic        pick_f, pick_d;
  logic        hit;
  logic        complete;
  logic [23:0] win_addr;
  logic        f_hit, d_hit;

`ifdef JT900H_RAMARB_CACHE_EN
  logic [23:0] f_tag, d_tag;
  logic [31:0] f_cdata, d_cdata;
  logic        f_valid, d_valid;

  assign f_hit = f_valid && (f_tag == f_addr);
  assign d_hit = d_valid && (d_tag == d_addr);

  // Every finished controller access refreshes the owner's cache entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
    end else if (cen && complete) begin
      if (gnt[0]) begin
        f_tag   <= ctl_addr;
        f_cdata <= ctl_dout;
        f_valid <= 1'b1;
      end
      if (gnt[1]) begin
        d_tag   <= ctl_addr;
        d_cdata <= ctl_dout;
        d_valid <= 1'b1;
      end
    end
  end
`else
  assign f_hit = 1'b0;
  assign d_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else if (cen)
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pick_f || pick_d) next_state = hit ? DONE : WAIT;
      WAIT: if (complete) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On a tie the port that did not win last time gets the controller
  always_comb begin
    pick_f   = 1'b0;
    pick_d   = 1'b0;
    if (state == IDLE) begin
      pick_f = f_req && (!d_req || last_d);
      pick_d = d_req && (!f_req || !last_d);
    end
    hit      = pick_f ? f_hit : (pick_d && d_hit);
    win_addr = pick_d ? d_addr : f_addr;
    complete = (state == WAIT) && !settle && ctl_rdy;
  end

  // The settle flag hides the first WAIT cycle, whose ctl_rdy may belong to the old address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_addr <= 24'd0;
      gnt      <= 2'b00;
      settle   <= 1'b0;
      last_d   <= 1'b1;
      f_rdy    <= 1'b0;
      d_rdy    <= 1'b0;
      f_dout   <= 32'd0;
      d_dout   <= 32'd0;
    end else if (cen) begin
      f_rdy <= 1'b0;
      d_rdy <= 1'b0;
      if (state == WAIT)
        settle <= 1'b0;
      if (pick_f || pick_d) begin
        gnt    <= {pick_d, pick_f};
        last_d <= pick_d;
        settle <= 1'b1;
        if (!hit)
          ctl_addr <= win_addr;
`ifdef JT900H_RAMARB_CACHE_EN
        if (hit && pick_f) begin
          f_rdy  <= 1'b1;
          f_dout <= f_cdata;
        end
        if (hit && pick_d) begin
          d_rdy  <= 1'b1;
          d_dout <= d_cdata;
        end
`endif
      end
      // A withdrawn request lets the access finish but leaves the port untouched
      if (complete) begin
        if (gnt[0] && f_req) begin
          f_rdy  <= 1'b1;
          f_dout <= ctl_dout;
        end
        if (gnt[1] && d_req) begin
          d_rdy  <= 1'b1;
          d_dout <= ctl_dout;
        end
      end
      if (state == DONE)
        gnt <= 2'b00;
    end
  end

endmodule

// File: tb/tb_jt900h_ramarb.sv
// tb_jt900h_ramarb: directed self-checking bench for jt900h_ramarb with a small ramctl model.
// The ramctl model raises ctl_rdy on the third cen edge of an access unless rdy_force holds it high.
`timescale 1ns/1ps
module tb_jt900h_ramarb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        f_req = 1'b0;
  logic        d_req = 1'b0;
  logic [23:0] f_addr = 24'd0;
  logic [23:0] d_addr = 24'd0;
  logic [31:0] f_dout, d_dout, ctl_dout;
  logic        f_rdy, d_rdy, ctl_rdy;
  logic [23:0] ctl_addr;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;
  bit rdy_force = 1'b0;
  bit cen_toggle = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  int age = 0;

  jt900h_ramarb dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .f_req(f_req), .f_addr(f_addr), .f_dout(f_dout), .f_rdy(f_rdy),
    .d_req(d_req), .d_addr(d_addr), .d_dout(d_dout), .d_rdy(d_rdy),
    .ctl_addr(ctl_addr), .ctl_dout(ctl_dout), .ctl_rdy(ctl_rdy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [23:0] a);
    logic [15:0] h;
    h = {a[7:1], 1'b1, a[7:1], 1'b0};
    return {h, h};
  endfunction

  assign ctl_dout = ram_word(ctl_addr);
  assign ctl_rdy  = rdy_force || ((gnt != 2'b00) && (age >= 2));

  // age counts cen edges since the grant became visible
  always @(posedge clk) begin
    if (cen) begin
      prev_gnt <= gnt;
      if (gnt != 2'b00 && prev_gnt == 2'b00) age <= 1;
      else if (gnt != 2'b00) age <= age + 1;
      else age <= 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clk1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    if (cen_toggle) begin
      cen = 1'b0;
      clk1();
    end
    cen = 1'b1;
    clk1();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit use_d, input bit on, input logic [23:0] addr);
    if (use_d) begin
      d_req  = on;
      d_addr = addr;
    end else begin
      f_req  = on;
      f_addr = addr;
    end
  endtask

  task automatic waitRdy(input bit use_d, output int n, output bit other);
    n = 0;
    other = 1'b0;
    while (n < 20 && !(use_d ? d_rdy : f_rdy)) begin
      tick();
      n++;
      if (use_d ? f_rdy : d_rdy) other = 1'b1;
    end
  endtask

  task automatic doAccess(input bit use_d, input logic [23:0] addr, input int exp_wait,
                          input logic [23:0] exp_ctl, input logic [31:0] exp_dout, input string tag);
    int n;
    bit other;
    applyStimulus(use_d, 1'b1, addr);
    tick();
    checkOutput({tag, " gnt"}, gnt, use_d ? 32'd2 : 32'd1);
    checkOutput({tag, " ctl_addr"}, ctl_addr, exp_ctl);
    waitRdy(use_d, n, other);
    checkOutput({tag, " latency"}, n, exp_wait);
    checkOutput({tag, " dout"}, use_d ? d_dout : f_dout, exp_dout);
    checkOutput({tag, " other rdy"}, other, 32'd0);
    applyStimulus(use_d, 1'b0, addr);
    tick();
    checkOutput({tag, " done gnt"}, gnt, 32'd0);
    checkOutput({tag, " rdy single"}, use_d ? d_rdy : f_rdy, 32'd0);
  endtask

  task automatic tieRound(input bit d_first, input logic [23:0] fa, input logic [31:0] fexp,
                          input logic [23:0] da, input logic [31:0] dexp, input string tag);
    int n;
    bit other;
    applyStimulus(1'b0, 1'b1, fa);
    applyStimulus(1'b1, 1'b1, da);
    tick();
    checkOutput({tag, " gnt first"}, gnt, d_first ? 32'd2 : 32'd1);
    waitRdy(d_first, n, other);
    checkOutput({tag, " first latency"}, n, 32'd3);
    checkOutput({tag, " first dout"}, d_first ? d_dout : f_dout, d_first ? dexp : fexp);
    applyStimulus(d_first, 1'b0, d_first ? da : fa);
    tick();
    checkOutput({tag, " gnt gap"}, gnt, 32'd0);
    tick();
    checkOutput({tag, " gnt second"}, gnt, d_first ? 32'd1 : 32'd2);
    checkOutput({tag, " second ctl_addr"}, ctl_addr, d_first ? fa : da);
    waitRdy(!d_first, n, other);
    checkOutput({tag, " second latency"}, n, 32'd3);
    checkOutput({tag, " second dout"}, d_first ? f_dout : d_dout, d_first ? fexp : dexp);
    applyStimulus(!d_first, 1'b0, d_first ? fa : da);
    tick();
    checkOutput({tag, " gnt end"}, gnt, 32'd0);
  endtask

  initial begin
    int n;
    bit other;
    bit seen;

    rst_n = 1'b0;
    repeat (3) clk1();
    checkOutput("reset gnt", gnt, 32'd0);
    checkOutput("reset ctl_addr", ctl_addr, 32'd0);
    checkOutput("reset f_rdy", f_rdy, 32'd0);
    checkOutput("reset d_rdy", d_rdy, 32'd0);
    checkOutput("reset f_dout", f_dout, 32'd0);
    checkOutput("reset d_dout", d_dout, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] tie after reset, then single fetch, then tie with data favoured");
    tieRound(1'b0, 24'h000010, 32'h11101110, 24'h000020, 32'h21202120, "tie A");
    doAccess(1'b0, 24'h00CAFE, 3, 24'h00CAFE, 32'hFFFEFFFE, "single fetch");
    tieRound(1'b1, 24'h000050, 32'h51505150, 24'h000060, 32'h61606160, "tie B");

    $display("[TB] stale ready held high");
    rdy_force = 1'b1;
    doAccess(1'b0, 24'h000070, 2, 24'h000070, 32'h71707170, "stale fetch");
    doAccess(1'b1, 24'h000080, 2, 24'h000080, 32'h81808180, "stale data");
    rdy_force = 1'b0;

    $display("[TB] data request withdrawn during WAIT");
    applyStimulus(1'b1, 1'b1, 24'h000090);
    tick();
    checkOutput("withdraw gnt", gnt, 32'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000090);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (d_rdy) seen = 1'b1;
    end
    checkOutput("withdraw d_rdy", seen, 32'd0);
    checkOutput("withdraw gnt idle", gnt, 32'd0);
    checkOutput("withdraw d_dout", d_dout, 32'h81808180);
    checkOutput("withdraw ctl_addr", ctl_addr, 32'h000090);
    doAccess(1'b0, 24'h0000A0, 3, 24'h0000A0, 32'hA1A0A1A0, "after withdraw");

    $display("[TB] cen toggling and reset during WAIT");
    cen_toggle = 1'b1;
    doAccess(1'b0, 24'h0000B0, 3, 24'h0000B0, 32'hB1B0B1B0, "cen fetch");
    applyStimulus(1'b0, 1'b1, 24'h0000C0);
    tick();
    waitRdy(1'b0, n, other);
    checkOutput("cen hold latency", n, 32'd3);
    checkOutput("cen hold dout", f_dout, 32'hC1C0C1C0);
    cen = 1'b0;
    clk1();
    checkOutput("cen rdy hold", f_rdy, 32'd1);
    applyStimulus(1'b0, 1'b0, 24'h0000C0);
    cen = 1'b1;
    clk1();
    checkOutput("cen rdy drop", f_rdy, 32'd0);
    checkOutput("cen gnt drop", gnt, 32'd0);

    applyStimulus(1'b0, 1'b1, 24'h0000D0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0000D0);
    cen = 1'b0;
    rst_n = 1'b0;
    clk1();
    rst_n = 1'b1;
    checkOutput("midreset gnt", gnt, 32'd0);
    checkOutput("midreset ctl_addr", ctl_addr, 32'd0);
    checkOutput("midreset f_rdy", f_rdy, 32'd0);
    checkOutput("midreset d_rdy", d_rdy, 32'd0);
    checkOutput("midreset f_dout", f_dout, 32'd0);
    checkOutput("midreset d_dout", d_dout, 32'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (f_rdy) seen = 1'b1;
    end
    checkOutput("midreset abandoned", seen, 32'd0);
    tieRound(1'b0, 24'h0000E0, 32'hE1E0E1E0, 24'h0000F0, 32'hF1F0F1F0, "post-reset tie");
    cen_toggle = 1'b0;

    $display("[TB] repeated fetch to one address");
    doAccess(1'b0, 24'h000100, 3, 24'h000100, 32'h01000100, "repeat first");
    doAccess(1'b1, 24'h000200, 3, 24'h000200, 32'h01000100, "repeat data");
`ifdef JT900H_RAMARB_CACHE_EN
    doAccess(1'b0, 24'h000100, 0, 24'h000200, 32'h01000100, "repeat hit");
`else
    doAccess(1'b0, 24'h000100, 3, 24'h000100, 32'h01000100, "repeat second");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
